// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit: state enum, opcodes,
// datapath select encodings and the packed control-output vector.
package ctrl_pkg;

  typedef enum logic [4:0] {
    S_PC_LD, S_FETCH, S_PC_INC, S_PC_WR, S_DECODE,
    S_EXEC_R, S_EXEC_I, S_EXEC_LHI, S_ADDR, S_MEM_RD, S_MEM_WR, S_WB,
    S_LMSM, S_BR_CMP, S_BR_TGT, S_PC_FIX, S_JAL_LNK, S_LNK_WR, S_JLR_TGT
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_LM  = 4'b0110;
  localparam logic [3:0] OP_SM  = 4'b0111;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;

  localparam logic [1:0] B_ZERO = 2'd0, B_ONE = 2'd1, B_RD2 = 2'd2, B_IMM6 = 2'd3;

  localparam logic [2:0] A_ZERO = 3'd0, A_ONE = 3'd1, A_LHI = 3'd2, A_IMM6 = 3'd3;
  localparam logic [2:0] A_IMM9 = 3'd4, A_RD1 = 3'd5, A_TMPA = 3'd6;

  localparam logic [1:0] WEN_OFF = 2'd0, WEN_ON = 2'd1, WEN_CZ = 2'd2, WEN_LM = 2'd3;

  localparam logic [2:0] WADD_IR119 = 3'd0, WADD_IR53 = 3'd1, WADD_CNT = 3'd2;
  localparam logic [2:0] WADD_R7 = 3'd3, WADD_IR86 = 3'd4;

  localparam logic [1:0] RD2_IR86 = 2'd0, RD2_CNT = 2'd1, RD2_R7 = 2'd2;

  localparam logic DIN_MEM = 1'b0, DIN_T1 = 1'b1;

  localparam logic [1:0] MWR_OFF = 2'd0, MWR_ON = 2'd1, MWR_SM = 2'd2;

  localparam logic MDIN_RD1 = 1'b0, MDIN_RD2 = 1'b1;

  typedef struct packed {
    logic [1:0] alu_b_sel;
    logic [2:0] alu_a_sel;
    logic [1:0] rf_wen_sel;
    logic [2:0] rf_wadd_sel;
    logic [1:0] rf_rd2_sel;
    logic       rf_din_sel;
    logic [1:0] mem_wr_sel;
    logic       mem_din_sel;
    logic       cz_en;
    logic       alu_op;
    logic       w_ir;
    logic       w_atmp;
    logic       reset_t1;
  } ctrl_out_t;

  localparam int unsigned CTRL_W = $bits(ctrl_out_t);

endpackage

// File: rtl/ctrl_decode.sv
// Moore output decode: current state plus latched opcode -> datapath control vector.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [4:0]        i_state,
  input  logic [3:0]        i_opcode,
  output logic [CTRL_W-1:0] o_ctrl
);

  state_t    w_state;
  ctrl_out_t w_c;

  assign w_state = state_t'(i_state);
  assign o_ctrl  = w_c;

  always_comb begin
    w_c = '0;
    unique case (w_state)
      S_PC_LD, S_JAL_LNK: begin
        w_c.rf_rd2_sel = RD2_R7;
        w_c.alu_a_sel  = A_ZERO;
        w_c.alu_b_sel  = B_RD2;
      end
      S_FETCH:  w_c.w_ir = 1'b1;
      S_PC_INC: begin
        w_c.rf_rd2_sel = RD2_R7;
        w_c.alu_a_sel  = A_ONE;
        w_c.alu_b_sel  = B_RD2;
      end
      S_PC_WR, S_PC_FIX: begin
        w_c.rf_wadd_sel = WADD_R7;
        w_c.rf_din_sel  = DIN_T1;
        w_c.rf_wen_sel  = WEN_ON;
      end
      S_DECODE: w_c.w_atmp = 1'b1;
      S_EXEC_R: begin
        w_c.alu_a_sel = A_RD1;
        w_c.alu_b_sel = B_RD2;
        w_c.alu_op    = i_opcode[1];
        w_c.cz_en     = 1'b1;
      end
      S_EXEC_I: begin
        w_c.alu_a_sel = A_RD1;
        w_c.alu_b_sel = B_IMM6;
        w_c.cz_en     = 1'b1;
      end
      S_EXEC_LHI: begin
        w_c.alu_a_sel = A_LHI;
        w_c.alu_b_sel = B_ZERO;
      end
      S_ADDR: begin
        w_c.alu_a_sel  = A_IMM6;
        w_c.alu_b_sel  = B_RD2;
        w_c.rf_rd2_sel = RD2_IR86;
      end
      S_MEM_RD: begin
        w_c.rf_wadd_sel = WADD_IR119;
        w_c.rf_din_sel  = DIN_MEM;
        w_c.rf_wen_sel  = WEN_ON;
        w_c.cz_en       = 1'b1;
      end
      S_MEM_WR: begin
        w_c.mem_wr_sel  = MWR_ON;
        w_c.mem_din_sel = MDIN_RD1;
      end
      S_WB: begin
        w_c.rf_din_sel = DIN_T1;
        if (i_opcode == OP_ADI) begin
          w_c.rf_wadd_sel = WADD_IR86;
          w_c.rf_wen_sel  = WEN_ON;
        end else if (i_opcode == OP_LHI) begin
          w_c.rf_wadd_sel = WADD_IR119;
          w_c.rf_wen_sel  = WEN_ON;
        end else begin
          w_c.rf_wadd_sel = WADD_IR53;
          w_c.rf_wen_sel  = WEN_CZ;
        end
      end
      // The per-slot offset is added on the address path; B stays idle here.
      S_LMSM: begin
        w_c.alu_a_sel   = A_TMPA;
        w_c.alu_b_sel   = B_ZERO;
        w_c.rf_rd2_sel  = RD2_CNT;
        w_c.rf_wadd_sel = WADD_CNT;
        if (i_opcode == OP_SM) begin
          w_c.mem_wr_sel  = MWR_SM;
          w_c.mem_din_sel = MDIN_RD2;
        end else begin
          w_c.rf_wen_sel = WEN_LM;
          w_c.rf_din_sel = DIN_MEM;
        end
      end
      S_BR_CMP: begin
        w_c.alu_a_sel = A_RD1;
        w_c.alu_b_sel = B_RD2;
      end
      S_BR_TGT: begin
        w_c.rf_rd2_sel = RD2_R7;
        w_c.alu_a_sel  = (i_opcode == OP_JAL) ? A_IMM9 : A_IMM6;
        w_c.alu_b_sel  = B_RD2;
      end
      S_LNK_WR: begin
        w_c.rf_wadd_sel = WADD_IR119;
        w_c.rf_din_sel  = DIN_T1;
        w_c.rf_wen_sel  = WEN_ON;
      end
      S_JLR_TGT: begin
        w_c.alu_a_sel  = A_ZERO;
        w_c.alu_b_sel  = B_RD2;
        w_c.rf_rd2_sel = RD2_IR86;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multicycle control unit for the 16-bit RISC core: holds state, IR copy and
// the LM/SM counter, and exposes the decoded datapath controls.
module control_fsm
  import ctrl_pkg::*;
#(
  parameter logic [2:0] LMSM_LAST = 3'd7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] mem_data,
  input  logic        compare,
  output logic [1:0]  alu_b_sel,
  output logic [2:0]  alu_a_sel,
  output logic [1:0]  rf_wen_sel,
  output logic [2:0]  rf_wadd_sel,
  output logic [1:0]  rf_rd2_sel,
  output logic        rf_din_sel,
  output logic [1:0]  mem_wr_sel,
  output logic        mem_din_sel,
  output logic        cz_en,
  output logic        alu_op,
  output logic        w_ir,
  output logic        w_atmp,
  output logic        reset_t1,
  output logic [2:0]  counter
);

  state_t              r_state;
  logic [15:0]         r_ir;
  logic [2:0]          r_counter;
  logic [3:0]          w_opcode;
  logic [CTRL_W-1:0]   w_dec;
  ctrl_out_t           w_out;
  logic                w_unused_fields;

  assign w_opcode        = r_ir[15:12];
  // Register fields are routed by the datapath's own IR; only the opcode matters here.
  assign w_unused_fields = ^r_ir[11:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_PC_LD;
      r_ir      <= '0;
      r_counter <= '0;
    end else begin
      unique case (r_state)
        S_PC_LD:  r_state <= S_FETCH;
        S_FETCH: begin
          r_ir    <= mem_data;
          r_state <= S_PC_INC;
        end
        S_PC_INC: r_state <= S_PC_WR;
        S_PC_WR:  r_state <= S_DECODE;
        S_DECODE: begin
          unique case (w_opcode)
            OP_ADD, OP_NDU: r_state <= S_EXEC_R;
            OP_ADI:         r_state <= S_EXEC_I;
            OP_LHI:         r_state <= S_EXEC_LHI;
            OP_LW, OP_SW:   r_state <= S_ADDR;
            OP_LM, OP_SM: begin
              r_state   <= S_LMSM;
              r_counter <= '0;
            end
            OP_BEQ:         r_state <= S_BR_CMP;
            OP_JAL, OP_JLR: r_state <= S_JAL_LNK;
            default:        r_state <= S_PC_LD;
          endcase
        end
        S_EXEC_R, S_EXEC_I, S_EXEC_LHI: r_state <= S_WB;
        S_ADDR:   r_state <= (w_opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD, S_MEM_WR, S_WB, S_PC_FIX: r_state <= S_PC_LD;
        S_LMSM: begin
          if (r_counter == LMSM_LAST) begin
            r_state   <= S_PC_LD;
            r_counter <= '0;
          end else begin
            r_counter <= r_counter + 3'd1;
          end
        end
        S_BR_CMP:  r_state <= compare ? S_BR_TGT : S_PC_LD;
        S_BR_TGT:  r_state <= S_PC_FIX;
        S_JAL_LNK: r_state <= S_LNK_WR;
        S_LNK_WR:  r_state <= (w_opcode == OP_JAL) ? S_BR_TGT : S_JLR_TGT;
        S_JLR_TGT: r_state <= S_PC_FIX;
        default:   r_state <= S_PC_LD;
      endcase
    end
  end

  ctrl_decode u_decode (
    .i_state  (r_state),
    .i_opcode (w_opcode),
    .o_ctrl   (w_dec)
  );

  // Reset forces the quiescent vector immediately, without waiting for a clock.
  always_comb begin
    w_out = ctrl_out_t'(w_dec);
    if (!reset_n) begin
      w_out          = '0;
      w_out.reset_t1 = 1'b1;
    end
  end

  assign alu_b_sel   = w_out.alu_b_sel;
  assign alu_a_sel   = w_out.alu_a_sel;
  assign rf_wen_sel  = w_out.rf_wen_sel;
  assign rf_wadd_sel = w_out.rf_wadd_sel;
  assign rf_rd2_sel  = w_out.rf_rd2_sel;
  assign rf_din_sel  = w_out.rf_din_sel;
  assign mem_wr_sel  = w_out.mem_wr_sel;
  assign mem_din_sel = w_out.mem_din_sel;
  assign cz_en       = w_out.cz_en;
  assign alu_op      = w_out.alu_op;
  assign w_ir        = w_out.w_ir;
  assign w_atmp      = w_out.w_atmp;
  assign reset_t1    = w_out.reset_t1;
  assign counter     = r_counter;

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: an instruction-level model expands each
// instruction into its expected per-cycle control vectors.
module tb_control_fsm;

  typedef struct packed {
    logic [1:0] b;
    logic [2:0] a;
    logic [1:0] wen;
    logic [2:0] wadd;
    logic [1:0] rd2;
    logic       din;
    logic [1:0] mw;
    logic       md;
    logic       cz;
    logic       op;
    logic       wir;
    logic       atmp;
    logic       rt1;
    logic [2:0] cnt;
  } obs_t;

  typedef struct {
    obs_t        v;
    logic [15:0] ir;
    int          step;
  } sb_t;

  logic        clk;
  logic        reset_n;
  logic [15:0] mem_data;
  logic        compare;
  logic [1:0]  alu_b_sel;
  logic [2:0]  alu_a_sel;
  logic [1:0]  rf_wen_sel;
  logic [2:0]  rf_wadd_sel;
  logic [1:0]  rf_rd2_sel;
  logic        rf_din_sel;
  logic [1:0]  mem_wr_sel;
  logic        mem_din_sel;
  logic        cz_en;
  logic        alu_op;
  logic        w_ir;
  logic        w_atmp;
  logic        reset_t1;
  logic [2:0]  counter;

  sb_t  sbq[$];
  obs_t seq[$];
  sb_t  mon_s;
  obs_t act;
  int   n_cmp = 0;
  int   n_err = 0;

  control_fsm #(.LMSM_LAST(3'd7)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_data    (mem_data),
    .compare     (compare),
    .alu_b_sel   (alu_b_sel),
    .alu_a_sel   (alu_a_sel),
    .rf_wen_sel  (rf_wen_sel),
    .rf_wadd_sel (rf_wadd_sel),
    .rf_rd2_sel  (rf_rd2_sel),
    .rf_din_sel  (rf_din_sel),
    .mem_wr_sel  (mem_wr_sel),
    .mem_din_sel (mem_din_sel),
    .cz_en       (cz_en),
    .alu_op      (alu_op),
    .w_ir        (w_ir),
    .w_atmp      (w_atmp),
    .reset_t1    (reset_t1),
    .counter     (counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb act = {alu_b_sel, alu_a_sel, rf_wen_sel, rf_wadd_sel, rf_rd2_sel, rf_din_sel,
                     mem_wr_sel, mem_din_sel, cz_en, alu_op, w_ir, w_atmp, reset_t1, counter};

  // Monitor: one expected vector per cycle whenever the scoreboard holds one.
  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      mon_s = sbq.pop_front();
      n_cmp++;
      if (act !== mon_s.v) begin
        n_err++;
        $display("FAIL ctrl_vec ir=%h step=%0d got=%h want=%h t=%0t",
                 mon_s.ir, mon_s.step, act, mon_s.v, $time);
      end
    end
  end

  function automatic obs_t pc_read(input logic [2:0] a_sel);
    obs_t e;
    e = '0;
    e.rd2 = 2'd2;
    e.a   = a_sel;
    e.b   = 2'd2;
    return e;
  endfunction

  function automatic obs_t rf_write(input logic [2:0] wadd, input logic [1:0] wen,
                                    input logic din);
    obs_t e;
    e = '0;
    e.wadd = wadd;
    e.wen  = wen;
    e.din  = din;
    return e;
  endfunction

  // Instruction-level reference: each instruction is a list of cycle vectors.
  task automatic build(input logic [15:0] ir, input bit cmp);
    obs_t       e;
    logic [3:0] op;
    op = ir[15:12];
    seq.delete();
    seq.push_back(pc_read(3'd0));
    e = '0; e.wir = 1'b1; seq.push_back(e);
    seq.push_back(pc_read(3'd1));
    seq.push_back(rf_write(3'd3, 2'd1, 1'b1));
    e = '0; e.atmp = 1'b1; seq.push_back(e);
    case (op)
      4'b0000, 4'b0010: begin
        e = '0; e.a = 3'd5; e.b = 2'd2; e.cz = 1'b1; e.op = ir[13]; seq.push_back(e);
        seq.push_back(rf_write(3'd1, 2'd2, 1'b1));
      end
      4'b0001: begin
        e = '0; e.a = 3'd5; e.b = 2'd3; e.cz = 1'b1; seq.push_back(e);
        seq.push_back(rf_write(3'd4, 2'd1, 1'b1));
      end
      4'b0011: begin
        e = '0; e.a = 3'd2; seq.push_back(e);
        seq.push_back(rf_write(3'd0, 2'd1, 1'b1));
      end
      4'b0100, 4'b0101: begin
        e = '0; e.a = 3'd3; e.b = 2'd2; seq.push_back(e);
        if (op == 4'b0100) begin
          e = rf_write(3'd0, 2'd1, 1'b0); e.cz = 1'b1; seq.push_back(e);
        end else begin
          e = '0; e.mw = 2'd1; seq.push_back(e);
        end
      end
      4'b0110, 4'b0111: begin
        for (int unsigned c = 0; c < 8; c++) begin
          e = '0; e.a = 3'd6; e.rd2 = 2'd1; e.wadd = 3'd2; e.cnt = 3'(c);
          if (op == 4'b0110) e.wen = 2'd3;
          else begin e.mw = 2'd2; e.md = 1'b1; end
          seq.push_back(e);
        end
      end
      4'b1100: begin
        e = '0; e.a = 3'd5; e.b = 2'd2; seq.push_back(e);
        if (cmp) begin
          seq.push_back(pc_read(3'd3));
          seq.push_back(rf_write(3'd3, 2'd1, 1'b1));
        end
      end
      4'b1000, 4'b1001: begin
        seq.push_back(pc_read(3'd0));
        seq.push_back(rf_write(3'd0, 2'd1, 1'b1));
        if (op == 4'b1000) seq.push_back(pc_read(3'd4));
        else begin e = '0; e.b = 2'd2; seq.push_back(e); end
        seq.push_back(rf_write(3'd3, 2'd1, 1'b1));
      end
      default: ;
    endcase
  endtask

  // Called at posedge+1 of the instruction's PC_LD cycle; abort>=0 truncates.
  task automatic run_instr(input logic [15:0] ir, input bit cmp, input int abort);
    int n;
    build(ir, cmp);
    mem_data = ir;
    compare  = cmp;
    n = (abort >= 0) ? abort : seq.size();
    for (int i = 0; i < n; i++) sbq.push_back('{seq[i], ir, i});
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int cycles);
    obs_t r;
    r = '0;
    r.rt1 = 1'b1;
    reset_n = 1'b0;
    repeat (cycles) begin
      sbq.push_back('{r, 16'h0000, -1});
      @(posedge clk);
      #1;
    end
    reset_n = 1'b1;
  endtask

  initial begin
    logic [15:0] rir;
    reset_n  = 1'b0;
    mem_data = '0;
    compare  = 1'b0;
    @(posedge clk);
    #1;
    do_reset(3);

    run_instr(16'h0050, 1'b0, -1);
    run_instr(16'h2A5B, 1'b0, -1);
    run_instr(16'h60A5, 1'b0, -1);
    run_instr(16'h7F3C, 1'b0, -1);
    run_instr(16'hC0C3, 1'b1, -1);
    run_instr(16'hC0C3, 1'b0, -1);
    run_instr(16'h9280, 1'b0, -1);
    run_instr(16'h8A11, 1'b0, -1);
    run_instr(16'h1234, 1'b0, -1);
    run_instr(16'h3E01, 1'b0, -1);
    run_instr(16'h4567, 1'b0, -1);
    run_instr(16'h5ABC, 1'b0, -1);
    run_instr(16'hF000, 1'b0, -1);

    run_instr(16'h60A5, 1'b0, 9);
    #1;
    do_reset(2);
    run_instr(16'h0050, 1'b0, -1);

    for (int k = 0; k < 80; k++) begin
      rir = 16'($urandom);
      run_instr(rir, 1'($urandom_range(0, 1)), -1);
    end

    repeat (3) @(negedge clk);
    if (sbq.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain pending=%0d required=0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time=%0t limit reached", $time);
    $fatal(1, "watchdog");
  end

endmodule
